// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
// Contents:
//   - funct3 load/store width codes
//   - default MMIO window base and register offsets
//   - FSM state encodings (IDLE, RD_WAIT, RESP)
package mem_access_unit_pkg;

  // funct3 width/sign codes
  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3Bu = 3'b100;
  localparam logic [2:0] Funct3Hu = 3'b101;

  // MMIO window: any address >= base is MMIO
  localparam logic [31:0] MmioBaseDefault = 32'hFFFF_FC00;
  localparam logic [9:0]  LedOfsDefault   = 10'h060;
  localparam logic [9:0]  SwOfsDefault    = 10'h070;

  // FSM state encodings
  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRdWait = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane selection and extension, purely combinational.
// Ports:
//   rdata    in  32  raw memory word
//   byte_ofs in  2   byte offset of the access within the word
//   funct3   in  3   load width/sign code
//   result   out 32  selected and sign/zero-extended load value
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_ofs,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (byte_ofs)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    // Halfword accesses are aligned, so only bit 1 picks the lane.
    half_sel = byte_ofs[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    case (funct3)
      Funct3B:  result = {{24{byte_sel[7]}}, byte_sel};
      Funct3H:  result = {{16{half_sel[15]}}, half_sel};
      Funct3Bu: result = {24'b0, byte_sel};
      Funct3Hu: result = {16'b0, half_sel};
      default:  result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage behind the execute ALU: RISC-V byte/half/word loads and stores against a
// 1-cycle-latency block RAM plus a small MMIO window (LEDs out, switches in).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid, mem_read,      request from execute (load has priority over store)
//   mem_write, funct3, addr,
//   store_data
//   stall                     hold the pipeline (combinational)
//   done, load_data, fault    one-cycle completion pulse with result / fault flag
//   ram_en, ram_we, ram_addr, block RAM interface (read data valid the cycle after ram_en)
//   ram_wdata, ram_rdata
//   switch_in, led_out        MMIO board I/O
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned RAM_AW    = 14,
  parameter logic [31:0] MMIO_BASE = MmioBaseDefault,
  parameter logic [9:0]  LED_OFS   = LedOfsDefault,
  parameter logic [9:0]  SW_OFS    = SwOfsDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic              done,
  output logic [31:0]       load_data,
  output logic              fault,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       switch_in,
  output logic [15:0]       led_out
);

  logic [1:0]  state_q, state_d;
  logic        fault_q;
  logic [31:0] load_data_q;
  logic [15:0] led_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;

  logic        accept;
  logic        is_load, is_store;
  logic        is_mmio, is_led, is_sw;
  logic [31:0] mmio_diff;
  logic        misaligned, illegal, mmio_bad, req_fault;
  logic [3:0]  store_we;
  logic [31:0] store_wdata;
  logic [31:0] mmio_rdata;
  logic [31:0] ext_data;

  // Request decode and fault check
  always_comb begin
    is_load   = mem_read;
    is_store  = ~mem_read & mem_write;
    accept    = (state_q == StIdle) & req_valid & (mem_read | mem_write);

    is_mmio   = addr >= MMIO_BASE;
    mmio_diff = addr - MMIO_BASE;
    is_led    = mmio_diff == {22'b0, LED_OFS};
    is_sw     = mmio_diff == {22'b0, SW_OFS};

    // funct3[1:0]==01 covers both h and hu
    misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                 ((funct3 == Funct3W) & (addr[1:0] != 2'b00));
    if (is_load) begin
      illegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    end else begin
      illegal = ~((funct3 == Funct3B) | (funct3 == Funct3H) | (funct3 == Funct3W));
    end
    // Only whole-word accesses to the two registers are legal in the window.
    mmio_bad  = is_mmio & ~((funct3 == Funct3W) & (is_led | is_sw));
    req_fault = misaligned | illegal | mmio_bad;

    mmio_rdata = is_sw ? {16'b0, switch_in} : {16'b0, led_q};
  end

  // Store lane steering
  always_comb begin
    store_we    = 4'b1111;
    store_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        store_we    = 4'b0001 << addr[1:0];
        store_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        store_we    = addr[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{store_data[15:0]}};
      end
      default: begin
        store_we    = 4'b1111;
        store_wdata = store_data;
      end
    endcase
  end

  // RAM is only touched in the accept cycle of a legal non-MMIO access.
  always_comb begin
    ram_en    = accept & ~req_fault & ~is_mmio;
    ram_we    = (ram_en & is_store) ? store_we : 4'b0000;
    ram_addr  = addr[RAM_AW+1:2];
    ram_wdata = store_wdata;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (ram_en & is_load) ? StRdWait : StResp;
        end
      end
      StRdWait: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  mem_access_unit_load_extend u_load_extend (
    .rdata    (ram_rdata),
    .byte_ofs (off_q),
    .funct3   (f3_q),
    .result   (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      fault_q     <= 1'b0;
      load_data_q <= 32'b0;
      led_q       <= 16'b0;
      off_q       <= 2'b0;
      f3_q        <= 3'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fault_q <= req_fault;
        off_q   <= addr[1:0];
        f3_q    <= funct3;
        if (~req_fault & is_mmio) begin
          if (is_load) begin
            load_data_q <= mmio_rdata;
          end else if (is_led) begin
            led_q <= store_data[15:0];
          end
        end
      end
      if (state_q == StRdWait) begin
        load_data_q <= ext_data;
      end
    end
  end

  always_comb begin
    done      = state_q == StResp;
    fault     = done & fault_q;
    stall     = accept | (state_q == StRdWait);
    load_data = load_data_q;
    led_out   = led_q;
  end

endmodule
